// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a unified 64-bit byte-addressed memory.
// Requester 0 is the CPU datapath and requester 1 is the loader/test port.
// Each granted access runs through IDLE -> ACC [-> WR] -> RESP. Sub-word
// stores use a read-modify-write so neighbouring bytes survive. Sub-word
// loads are zero- or sign-extended to 64 bits.

module mem_port_arbiter #(
   parameter int MEM_BYTES  = 65536,
   parameter int RESET_LAST = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req,
   input  logic [63:0] r0_adr,
   input  logic [63:0] r0_wdata,
   input  logic        r0_we,
   input  logic [1:0]  r0_size,
   input  logic        r0_uns,
   input  logic [63:0] r1_adr,
   input  logic [63:0] r1_wdata,
   input  logic        r1_we,
   input  logic [1:0]  r1_size,
   input  logic        r1_uns,
   output logic [1:0]  ack,
   output logic        err,
   output logic [63:0] rdata,
   output logic        busy,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [63:0] adr,
   output logic [63:0] mem_data_in,
   input  logic [63:0] mem_data_out
);

   // Highest legal start address: a full 8-byte window must fit in memory.
   localparam logic [63:0] ADR_MAX = 64'(MEM_BYTES - 8);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      WR   = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t      state;

   // Control latched at grant
   logic        last_q;
   logic        id_q;
   logic        we_q;
   logic        uns_q;
   logic        oor_q;
   logic [1:0]  sz_q;

   // Store data latched at grant
   logic [63:0] wdata_q;

   // Selected requester's view of the inputs
   logic        grant;
   logic        gnt_id;
   logic [63:0] sel_adr;
   logic [63:0] sel_wdata;
   logic        sel_we;
   logic [1:0]  sel_size;
   logic        sel_uns;
   logic        sel_oor;
   logic        sel_dbl_st;

   // Extract the low 8*2^sz bits and extend them to 64 bits. The field is
   // shifted to the top and shifted back so one arithmetic shift does the
   // sign extension for every size.
   function automatic logic [63:0] load_ext(input logic [63:0] d,
                                            input logic [1:0]  sz,
                                            input logic        uns);
      logic [6:0]         sh;
      logic [63:0]        up;
      logic signed [63:0] sup;
      sh  = 7'd64 - (7'd8 << sz);
      up  = d << sh;
      sup = up;
      if (uns)
         load_ext = up >> sh;
      else
         load_ext = sup >>> sh;
   endfunction

   // Replace the low 2^sz bytes of the current memory word with store data.
   function automatic logic [63:0] merge_bytes(input logic [63:0] old,
                                               input logic [63:0] nw,
                                               input logic [1:0]  sz);
      logic [7:0] be;
      case (sz)
         2'd0:    be = 8'h01;
         2'd1:    be = 8'h03;
         2'd2:    be = 8'h0F;
         default: be = 8'hFF;
      endcase
      merge_bytes = old;
      for (int i = 0; i < 8; i++) begin
         if (be[i])
            merge_bytes[8*i +: 8] = nw[8*i +: 8];
      end
   endfunction

   // One-hot completion pulse for the latched requester.
   function automatic logic [1:0] ack_for(input logic id);
      ack_for = id ? 2'b10 : 2'b01;
   endfunction

   assign grant = (state == IDLE) && (req != 2'b00);

   // Pick the requester: a lone request wins; a tie goes to the one not last served.
   always_comb begin
      gnt_id = req[1];
      if (req == 2'b11)
         gnt_id = ~last_q;
   end

   assign sel_adr    = gnt_id ? r1_adr   : r0_adr;
   assign sel_wdata  = gnt_id ? r1_wdata : r0_wdata;
   assign sel_we     = gnt_id ? r1_we    : r0_we;
   assign sel_size   = gnt_id ? r1_size  : r0_size;
   assign sel_uns    = gnt_id ? r1_uns   : r0_uns;
   // Unsigned 64-bit compare, so huge addresses are rejected rather than wrapping.
   assign sel_oor    = sel_adr > ADR_MAX;
   assign sel_dbl_st = sel_we && (sel_size == 2'd3);

   // Store data capture; it is only consumed after a grant, so it needs no reset.
   always_ff @(posedge clk) begin
      if (grant)
         wdata_q <= sel_wdata;
   end

   // Access sequencer with registered memory-side and requester-side outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         last_q      <= (RESET_LAST != 0);
         id_q        <= 1'b0;
         we_q        <= 1'b0;
         uns_q       <= 1'b0;
         oor_q       <= 1'b0;
         sz_q        <= 2'd0;
         ack         <= 2'b00;
         err         <= 1'b0;
         rdata       <= '0;
         busy        <= 1'b0;
         MemRead     <= 1'b0;
         MemWrite    <= 1'b0;
         adr         <= '0;
         mem_data_in <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  id_q   <= gnt_id;
                  we_q   <= sel_we;
                  sz_q   <= sel_size;
                  uns_q  <= sel_uns;
                  oor_q  <= sel_oor;
                  last_q <= gnt_id;
                  busy   <= 1'b1;
                  adr    <= sel_adr;
                  // The ACC cycle's memory strobes are decided here so they are
                  // already valid while the latched access is in ACC. A double
                  // store writes directly; everything else in range reads first.
                  MemRead     <= !sel_oor && !sel_dbl_st;
                  MemWrite    <= !sel_oor && sel_dbl_st;
                  mem_data_in <= (!sel_oor && sel_dbl_st) ? sel_wdata : '0;
                  state       <= ACC;
               end
            end

            ACC: begin
               if (oor_q) begin
                  err         <= 1'b1;
                  rdata       <= '0;
                  ack         <= ack_for(id_q);
                  adr         <= '0;
                  MemRead     <= 1'b0;
                  MemWrite    <= 1'b0;
                  mem_data_in <= '0;
                  state       <= RESP;
               end else if (!we_q) begin
                  rdata   <= load_ext(mem_data_out, sz_q, uns_q);
                  ack     <= ack_for(id_q);
                  adr     <= '0;
                  MemRead <= 1'b0;
                  state   <= RESP;
               end else if (sz_q == 2'd3) begin
                  // The full-width write completes on this edge; rdata is held.
                  ack         <= ack_for(id_q);
                  adr         <= '0;
                  MemWrite    <= 1'b0;
                  mem_data_in <= '0;
                  state       <= RESP;
               end else begin
                  // Sub-word store: merge into the word just read, write it next.
                  mem_data_in <= merge_bytes(mem_data_out, wdata_q, sz_q);
                  MemRead     <= 1'b0;
                  MemWrite    <= 1'b1;
                  state       <= WR;
               end
            end

            WR: begin
               ack         <= ack_for(id_q);
               adr         <= '0;
               MemWrite    <= 1'b0;
               mem_data_in <= '0;
               state       <= RESP;
            end

            RESP: begin
               ack   <= 2'b00;
               err   <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural byte memory, scoreboard queue of
// expected completions, one task per scenario.

module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req = 2'b00;
   logic [63:0] r0_adr = '0, r0_wdata = '0, r1_adr = '0, r1_wdata = '0;
   logic        r0_we = 1'b0, r0_uns = 1'b0, r1_we = 1'b0, r1_uns = 1'b0;
   logic [1:0]  r0_size = 2'd0, r1_size = 2'd0;
   logic [1:0]  ack;
   logic        err;
   logic [63:0] rdata;
   logic        busy;
   logic        MemRead;
   logic        MemWrite;
   logic [63:0] adr;
   logic [63:0] mem_data_in;
   logic [63:0] mem_data_out;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MEM_BYTES(65536), .RESET_LAST(1)) dut (
      .clk(clk), .rst(rst), .req(req),
      .r0_adr(r0_adr), .r0_wdata(r0_wdata), .r0_we(r0_we), .r0_size(r0_size), .r0_uns(r0_uns),
      .r1_adr(r1_adr), .r1_wdata(r1_wdata), .r1_we(r1_we), .r1_size(r1_size), .r1_uns(r1_uns),
      .ack(ack), .err(err), .rdata(rdata), .busy(busy),
      .MemRead(MemRead), .MemWrite(MemWrite), .adr(adr),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
   );

   // Behavioural memory: combinational read, 8-byte little-endian write.
   logic [7:0]  mem [0:65535];
   logic        poke_en = 1'b0;
   logic [15:0] poke_adr = '0;
   logic [63:0] poke_dat = '0;

   always_comb begin
      mem_data_out = '0;
      if (adr <= 64'd65528)
         for (int i = 0; i < 8; i++)
            mem_data_out[8*i +: 8] = mem[adr[15:0] + 16'(i)];
   end

   always @(posedge clk) begin
      if (poke_en) begin
         for (int i = 0; i < 8; i++) mem[poke_adr + 16'(i)] <= poke_dat[8*i +: 8];
      end else if (MemWrite && adr <= 64'd65528) begin
         for (int i = 0; i < 8; i++) mem[adr[15:0] + 16'(i)] <= mem_data_in[8*i +: 8];
      end
   end

   int wr_cnt = 0;
   int rd_cnt = 0;
   always @(negedge clk) begin
      if (MemWrite) wr_cnt <= wr_cnt + 1;
      if (MemRead)  rd_cnt <= rd_cnt + 1;
   end

   typedef struct {
      logic [1:0]  ack;
      logic        err;
      logic        chk_rd;
      logic [63:0] rdata;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic poke8(input int a, input logic [63:0] d);
      poke_adr = 16'(a);
      poke_dat = d;
      poke_en  = 1'b1;
      @(posedge clk); #1;
      poke_en  = 1'b0;
   endtask

   function automatic logic [63:0] peek8(input int a);
      for (int i = 0; i < 8; i++) peek8[8*i +: 8] = mem[a + i];
   endfunction

   task automatic drive(input int id, input logic [63:0] a, input logic [63:0] wd,
                        input logic we, input logic [1:0] sz, input logic uns);
      if (id == 0) begin
         r0_adr = a; r0_wdata = wd; r0_we = we; r0_size = sz; r0_uns = uns; req[0] = 1'b1;
      end else begin
         r1_adr = a; r1_wdata = wd; r1_we = we; r1_size = sz; r1_uns = uns; req[1] = 1'b1;
      end
   endtask

   // Cycle in which the call starts counts as 1; returns on the first ack.
   task automatic wait_ack(output int lat, output bit to);
      lat = 1;
      to  = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         lat++;
         if (ack != 2'b00) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({ack, err, busy, MemRead, MemWrite} !== 6'b0) begin
         bad++; $display("FAIL reset_ctl: got %b want 000000", {ack, err, busy, MemRead, MemWrite});
      end
      total++;
      if (adr !== 64'd0) begin bad++; $display("FAIL reset_adr: got %h want 0", adr); end
      total++;
      if (mem_data_in !== 64'd0) begin bad++; $display("FAIL reset_wdata: got %h want 0", mem_data_in); end
      total++;
      if (rdata !== 64'd0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_load_double();
      int   lat;
      bit   to;
      exp_t e;
      poke8(1000, 64'h0807060504030201);
      sb.push_back('{ack: 2'b01, err: 1'b0, chk_rd: 1'b1, rdata: 64'h0807060504030201, lat: 3});
      drive(0, 64'd1000, 64'd0, 1'b0, 2'd3, 1'b0);
      wait_ack(lat, to);
      req = 2'b00;
      e = sb.pop_front();
      total++;
      if (to) begin bad++; $display("FAIL ldd_timeout: no ack within budget"); end
      total++;
      if (ack !== e.ack || err !== e.err) begin
         bad++; $display("FAIL ldd_ack: got ack=%b err=%b want ack=%b err=%b", ack, err, e.ack, e.err);
      end
      total++;
      if (rdata !== e.rdata) begin bad++; $display("FAIL ldd_rdata: got %h want %h", rdata, e.rdata); end
      total++;
      if (lat != e.lat) begin bad++; $display("FAIL ldd_latency: got %0d want %0d", lat, e.lat); end
      @(posedge clk); #1;
      total++;
      if ({ack, err, busy} !== 4'b0) begin
         bad++; $display("FAIL ldd_idle: got ack=%b err=%b busy=%b want all 0", ack, err, busy);
      end
   endtask

   task automatic test_stores();
      int          ids[4]  = '{0, 1, 1, 0};
      logic [63:0] adrs[4] = '{64'd1500, 64'd1504, 64'd1600, 64'd1607};
      logic [63:0] wds[4]  = '{64'hFFFFFFFF_AABBCCDD, 64'h00000000_0000BEEF,
                               64'hDEADBEEF_01234567, 64'h00000000_000000A5};
      logic [1:0]  szs[4]  = '{2'd2, 2'd1, 2'd3, 2'd0};
      int          pk[4]   = '{1500, 1500, 1600, 1600};
      logic [63:0] pexp[4] = '{64'h11111111_AABBCCDD, 64'h1111BEEF_AABBCCDD,
                               64'hDEADBEEF_01234567, 64'hA5ADBEEF_01234567};
      int          lats[4] = '{4, 4, 3, 4};
      int          lat;
      bit          to;
      int          wr0;
      exp_t        e;
      poke8(1500, 64'h11111111_11111111);
      poke8(1600, 64'h0);
      for (int i = 0; i < 4; i++) begin
         wr0 = wr_cnt;
         sb.push_back('{ack: (ids[i] == 1) ? 2'b10 : 2'b01, err: 1'b0, chk_rd: 1'b0,
                        rdata: 64'd0, lat: lats[i]});
         drive(ids[i], adrs[i], wds[i], 1'b1, szs[i], 1'b0);
         wait_ack(lat, to);
         req = 2'b00;
         e = sb.pop_front();
         total++;
         if (to || ack !== e.ack || err !== e.err) begin
            bad++; $display("FAIL st_ack row %0d: got ack=%b err=%b to=%0d want ack=%b err=%b",
                            i, ack, err, to, e.ack, e.err);
         end
         total++;
         if (lat != e.lat) begin bad++; $display("FAIL st_latency row %0d: got %0d want %0d", i, lat, e.lat); end
         @(posedge clk); #1;
         total++;
         if (peek8(pk[i]) !== pexp[i]) begin
            bad++; $display("FAIL st_mem row %0d: got %h want %h", i, peek8(pk[i]), pexp[i]);
         end
         total++;
         if (wr_cnt - wr0 != 1) begin
            bad++; $display("FAIL st_wrcycles row %0d: got %0d want 1", i, wr_cnt - wr0);
         end
      end
   endtask

   task automatic test_load_ext();
      int          ids[7]  = '{1, 1, 0, 0, 1, 0, 1};
      logic [63:0] adrs[7] = '{64'd2000, 64'd2000, 64'd3000, 64'd3000, 64'd3002, 64'd3000, 64'd3000};
      logic [1:0]  szs[7]  = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd1, 2'd1, 2'd3};
      logic        unss[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [63:0] exps[7] = '{64'hFFFFFFFF_FFFFFF80, 64'h00000000_00000080,
                               64'hFFFFFFFF_F1223344, 64'h00000000_F1223344,
                               64'hFFFFFFFF_FFFFF122, 64'h00000000_00003344,
                               64'h55555555_F1223344};
      int          lat;
      bit          to;
      exp_t        e;
      poke8(2000, 64'h7F7F7F7F_7F7F7F80);
      poke8(3000, 64'h55555555_F1223344);
      poke8(3008, 64'h0);
      for (int i = 0; i < 7; i++) begin
         sb.push_back('{ack: (ids[i] == 1) ? 2'b10 : 2'b01, err: 1'b0, chk_rd: 1'b1,
                        rdata: exps[i], lat: 3});
         drive(ids[i], adrs[i], 64'd0, 1'b0, szs[i], unss[i]);
         wait_ack(lat, to);
         req = 2'b00;
         e = sb.pop_front();
         total++;
         if (to || ack !== e.ack || err !== e.err || lat != e.lat) begin
            bad++; $display("FAIL ext_ack row %0d: got ack=%b err=%b lat=%0d want ack=%b err=%b lat=%0d",
                            i, ack, err, lat, e.ack, e.err, e.lat);
         end
         total++;
         if (e.chk_rd && rdata !== e.rdata) begin
            bad++; $display("FAIL ext_rdata row %0d: got %h want %h", i, rdata, e.rdata);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_fairness();
      int   lat;
      bit   to;
      exp_t e;
      rst = 1'b1;
      req = 2'b00;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      // First ack counted from req assertion; later ones from the previous ack cycle.
      for (int i = 0; i < 4; i++) begin
         sb.push_back('{ack: (i % 2 == 1) ? 2'b10 : 2'b01, err: 1'b0, chk_rd: 1'b1,
                        rdata: (i % 2 == 1) ? 64'h80 : 64'h0807060504030201,
                        lat: (i == 0) ? 3 : 4});
      end
      drive(0, 64'd1000, 64'd0, 1'b0, 2'd3, 1'b0);
      drive(1, 64'd2000, 64'd0, 1'b0, 2'd0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         wait_ack(lat, to);
         e = sb.pop_front();
         total++;
         if (to || ack !== e.ack || err !== e.err) begin
            bad++; $display("FAIL fair_order grant %0d: got ack=%b err=%b to=%0d want ack=%b",
                            i, ack, err, to, e.ack);
         end
         total++;
         if (rdata !== e.rdata || lat != e.lat) begin
            bad++; $display("FAIL fair_data grant %0d: got rdata=%h lat=%0d want rdata=%h lat=%0d",
                            i, rdata, lat, e.rdata, e.lat);
         end
      end
      req = 2'b00;
      @(posedge clk); #1;
      total++;
      if ({ack, err} !== 3'b0) begin bad++; $display("FAIL fair_quiet: got ack=%b err=%b want 0", ack, err); end
   endtask

   task automatic test_range();
      int          ids[6]  = '{0, 0, 1, 1, 0, 1};
      logic [63:0] adrs[6] = '{64'd65528, 64'd65529, 64'd65528, 64'hFFFFFFFF_FFFFFFFC,
                               64'd65528, 64'd65535};
      logic        wes[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [1:0]  szs[6]  = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
      logic        errs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      int          rds[6]  = '{1, 0, 1, 0, 1, 0};
      logic [63:0] good    = 64'hF0E0D0C0_B0A09080;
      int          lat;
      bit          to;
      int          rd0;
      int          wr0;
      exp_t        e;
      poke8(65528, good);
      for (int i = 0; i < 6; i++) begin
         rd0 = rd_cnt;
         wr0 = wr_cnt;
         sb.push_back('{ack: (ids[i] == 1) ? 2'b10 : 2'b01, err: errs[i], chk_rd: 1'b1,
                        rdata: errs[i] ? 64'd0 : good, lat: 3});
         drive(ids[i], adrs[i], 64'hFF, wes[i], szs[i], 1'b0);
         wait_ack(lat, to);
         req = 2'b00;
         e = sb.pop_front();
         total++;
         if (to || ack !== e.ack || err !== e.err || lat != e.lat) begin
            bad++; $display("FAIL rng_ack row %0d: got ack=%b err=%b lat=%0d want ack=%b err=%b lat=%0d",
                            i, ack, err, lat, e.ack, e.err, e.lat);
         end
         total++;
         if (rdata !== e.rdata) begin bad++; $display("FAIL rng_rdata row %0d: got %h want %h", i, rdata, e.rdata); end
         total++;
         if (rd_cnt - rd0 != rds[i] || wr_cnt - wr0 != 0) begin
            bad++; $display("FAIL rng_strobes row %0d: got rd=%0d wr=%0d want rd=%0d wr=0",
                            i, rd_cnt - rd0, wr_cnt - wr0, rds[i]);
         end
         @(posedge clk); #1;
      end
      total++;
      if (peek8(65528) !== good) begin bad++; $display("FAIL rng_mem: got %h want %h", peek8(65528), good); end
   endtask

   task automatic test_reset_in_wr();
      int   lat;
      bit   to;
      int   wr0;
      int   nack;
      exp_t e;
      poke8(1700, 64'h22222222_22222222);
      wr0 = wr_cnt;
      drive(0, 64'd1700, 64'h99, 1'b1, 2'd0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      total++;
      if (MemWrite !== 1'b1) begin bad++; $display("FAIL rwr_reach: got MemWrite=%b want 1", MemWrite); end
      rst = 1'b1;
      #1;
      total++;
      if ({MemWrite, busy, ack} !== 4'b0) begin
         bad++; $display("FAIL rwr_abort: got MemWrite=%b busy=%b ack=%b want 0", MemWrite, busy, ack);
      end
      req = 2'b00;
      @(posedge clk); #1;
      rst = 1'b0;
      nack = 0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         if (ack != 2'b00) nack++;
      end
      total++;
      if (nack != 0) begin bad++; $display("FAIL rwr_noack: got %0d acks want 0", nack); end
      total++;
      if (peek8(1700) !== 64'h22222222_22222222 || wr_cnt - wr0 != 0) begin
         bad++; $display("FAIL rwr_mem: got %h writes=%0d want 2222222222222222 writes=0",
                         peek8(1700), wr_cnt - wr0);
      end
      sb.push_back('{ack: 2'b10, err: 1'b0, chk_rd: 1'b1, rdata: 64'h22222222_22222222, lat: 3});
      drive(1, 64'd1700, 64'd0, 1'b0, 2'd3, 1'b0);
      wait_ack(lat, to);
      req = 2'b00;
      e = sb.pop_front();
      total++;
      if (to || ack !== e.ack || rdata !== e.rdata || lat != e.lat) begin
         bad++; $display("FAIL rwr_next: got ack=%b rdata=%h lat=%0d want ack=%b rdata=%h lat=%0d",
                         ack, rdata, lat, e.ack, e.rdata, e.lat);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_load_double();
      test_stores();
      test_load_ext();
      test_fairness();
      test_range();
      test_reset_in_wr();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
